// File: rtl/sseg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : sseg_scan_ctrl_if
// Producer-side handshake bundle for sseg_scan_ctrl: eight digit patterns plus valid/ready.
// Rev    : 1.0
// ============================================================================
interface sseg_scan_ctrl_if;
  logic [55:0] seg_in;
  logic        upd_valid;
  logic        upd_ready;

  modport master (
    output seg_in,
    output upd_valid,
    input  upd_ready
  );

  modport slave (
    input  seg_in,
    input  upd_valid,
    output upd_ready
  );
endinterface : sseg_scan_ctrl_if
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sseg_scan_ctrl
// Double-buffered, tear-free seven-segment scanner.
// Build option SSEG_SCAN_LZ_BLANK_EN enables leading-zero blanking at commit.
// Rev    : 1.0
// ============================================================================
module sseg_scan_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int GUARD      = 16,
  parameter int NUM_DIGITS = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  sseg_scan_ctrl_if.slave upd,
  output logic [7:0]      an,
  output logic [6:0]      seg,
  output logic            frame_done
);

  localparam int                 c_cnt_w      = $clog2(TICK_DIV);
  localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(GUARD - 1);
  localparam logic [c_cnt_w-1:0] c_slot_last  = c_cnt_w'(TICK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_fd_cnt     = c_cnt_w'(TICK_DIV - 2);
  localparam logic [2:0]         c_idx_last   = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]         c_blank      = 7'h7F;
  localparam logic [6:0]         c_zero       = 7'h01;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic               r_pending;
  logic [6:0]         r_active     [8];
  logic [6:0]         r_shadow     [8];
  logic [6:0]         w_seg_in     [8];
  logic [6:0]         w_commit_img [8];
  logic [7:0]         w_an_drive;
  logic               w_accept;
  logic               w_commit;

  generate
    for (genvar k = 0; k < 8; k++) begin : g_unpack
      assign w_seg_in[k] = upd.seg_in[7*k +: 7];
    end
  endgenerate

  assign upd.upd_ready = ~r_pending;
  assign w_accept      = upd.upd_valid & ~r_pending;
  assign w_commit      = (r_state == S_DRIVE) && (r_cnt == c_slot_last) && (r_idx == c_idx_last);
  assign w_an_drive    = ~(8'd1 << r_idx);

  // Image copied into the active buffer at the frame boundary; unused digits stay blank.
`ifdef SSEG_SCAN_LZ_BLANK_EN
  logic w_lead;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_commit_img[k] = (k < NUM_DIGITS) ? r_shadow[k] : c_blank;
    end
    w_lead = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (k < NUM_DIGITS) begin
        if (w_lead && ((w_commit_img[k] == c_blank) || (w_commit_img[k] == c_zero))) begin
          w_commit_img[k] = c_blank;
        end else begin
          w_lead = 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_commit_img[k] = (k < NUM_DIGITS) ? r_shadow[k] : c_blank;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BLANK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      an         <= 8'hFF;
      seg        <= c_blank;
      frame_done <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        r_active[k] <= c_blank;
        r_shadow[k] <= c_blank;
      end
    end else begin
      r_cnt <= (r_cnt == c_slot_last) ? '0 : r_cnt + 1'b1;

      // Registered one cycle early so the pulse lines up with the commit cycle itself.
      frame_done <= (r_state == S_DRIVE) && (r_cnt == c_fd_cnt) && (r_idx == c_idx_last);

      case (r_state)
        S_BLANK: begin
          if (r_cnt == c_guard_last) begin
            r_state <= S_DRIVE;
            an      <= w_an_drive;
            seg     <= r_active[r_idx];
          end
        end
        S_DRIVE: begin
          if (r_cnt == c_slot_last) begin
            r_state <= S_BLANK;
            an      <= 8'hFF;
            seg     <= c_blank;
            r_idx   <= (r_idx == c_idx_last) ? 3'd0 : r_idx + 3'd1;
          end
        end
        default: begin
          r_state <= S_BLANK;
          an      <= 8'hFF;
          seg     <= c_blank;
        end
      endcase

      // Commit needs pending=1 and accept needs pending=0, so they never collide.
      if (w_commit && r_pending) begin
        r_pending <= 1'b0;
        for (int k = 0; k < 8; k++) begin
          r_active[k] <= w_commit_img[k];
        end
      end else if (w_accept) begin
        r_pending <= 1'b1;
        for (int k = 0; k < 8; k++) begin
          r_shadow[k] <= w_seg_in[k];
        end
      end
    end
  end

endmodule : sseg_scan_ctrl
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sseg_scan_ctrl
// Directed scoreboard bench for sseg_scan_ctrl (TICK_DIV=8, GUARD=2, NUM_DIGITS=8).
// Rev    : 1.0
// ============================================================================
module tb_sseg_scan_ctrl;

  localparam int TICK_DIV   = 8;
  localparam int GUARD      = 2;
  localparam int NUM_DIGITS = 8;
  localparam int FRAME      = TICK_DIV * NUM_DIGITS;

  typedef struct packed {
    logic [31:0] at;
    logic [55:0] pats;
  } sb_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_done;

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .GUARD      (GUARD),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (bus),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         k     = 0;
  int         acc_cnt;
  sb_t        sb [$];
  logic [6:0] disp [8];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d: observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [55:0] lz(input logic [55:0] p);
    logic [55:0] r;
    r = p;
`ifdef SSEG_SCAN_LZ_BLANK_EN
    for (int d = 7; d >= 1; d--) begin
      if ((r[7*d +: 7] == 7'h7F) || (r[7*d +: 7] == 7'h01)) r[7*d +: 7] = 7'h7F;
      else break;
    end
`endif
    return r;
  endfunction

  task automatic chk_reset();
    check("rst_an", an, 8'hFF);
    check("rst_seg", 8'(seg), 8'h7F);
    check("rst_ready", 8'(bus.upd_ready), 8'h01);
    check("rst_frame_done", 8'(frame_done), 8'h00);
  endtask

  // One clock: scoreboard push/pop plus full comparison of every output.
  task automatic tick();
    logic        acc;
    logic [55:0] din;
    sb_t         e;
    int          slot;
    int          phase;
    acc = bus.upd_valid && (sb.size() == 0);
    din = bus.seg_in;
    @(posedge clk);
    #1;
    k++;
    if ((sb.size() != 0) && (int'(sb[0].at) == k)) begin
      for (int d = 0; d < 8; d++) disp[d] = sb[0].pats[7*d +: 7];
      void'(sb.pop_front());
    end
    if (acc) begin
      e.at   = 32'((k / FRAME + 1) * FRAME);
      e.pats = lz(din);
      sb.push_back(e);
    end
    slot  = (k / TICK_DIV) % NUM_DIGITS;
    phase = k % TICK_DIV;
    check("an", an, (phase < GUARD) ? 8'hFF : ~(8'd1 << slot));
    check("seg", 8'(seg), (phase < GUARD) ? 8'h7F : 8'(disp[slot]));
    check("frame_done", 8'(frame_done), ((k % FRAME) == FRAME - 1) ? 8'h01 : 8'h00);
    check("upd_ready", 8'(bus.upd_ready), (sb.size() == 0) ? 8'h01 : 8'h00);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic goto(input int slot, input int phase);
    for (int i = 0; i < FRAME; i++) begin
      if ((k % FRAME) == slot * TICK_DIV + phase) break;
      tick();
    end
  endtask

  task automatic send(input logic [55:0] p);
    bus.seg_in    = p;
    bus.upd_valid = 1'b1;
    tick();
    bus.upd_valid = 1'b0;
    bus.seg_in    = '1;
  endtask

  task automatic model_restart();
    k = 0;
    sb.delete();
    for (int d = 0; d < 8; d++) disp[d] = 7'h7F;
  endtask

  initial begin
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.upd_valid = 1'b0;
    bus.seg_in    = '1;
    model_restart();

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_reset();
    end
    rst_n = 1'b1;

    // Scan order: digit k shows decoder pattern for k
    send({7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01});
    run(2 * FRAME + 10);

    // Tear-free update while digit 3 is being driven
    goto(3, 4);
    send({7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F});
    goto(0, 2);
    check("tear_d0_new", 8'(seg), 8'h0F);
    run(FRAME);

    // Back-pressure: valid held high with changing data
    goto(1, 2);
    acc_cnt = 0;
    bus.upd_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      bus.seg_in = {$urandom(), $urandom()};
      if (bus.upd_ready) acc_cnt++;
      tick();
    end
    bus.upd_valid = 1'b0;
    bus.seg_in    = '1;
    check("bp_accepts", 8'(acc_cnt), 8'd3);
    run(2 * FRAME);

    // Async reset mid-drive discards the pending shadow
    goto(4, 3);
    send({8{7'h06}});
    goto(5, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset();
    end
    rst_n = 1'b1;
    model_restart();
    run(2 * FRAME + 4);

    // Leading-zero handling
    send({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h01, 7'h4C, 7'h12});
    goto(0, 2);
    goto(2, 4);
`ifdef SSEG_SCAN_LZ_BLANK_EN
    check("lz_d2", 8'(seg), 8'h7F);
`else
    check("lz_d2", 8'(seg), 8'h01);
`endif
    send({8{7'h01}});
    goto(0, 2);
    goto(7, 4);
`ifdef SSEG_SCAN_LZ_BLANK_EN
    check("lz_all0_d7", 8'(seg), 8'h7F);
`else
    check("lz_all0_d7", 8'(seg), 8'h01);
`endif
    goto(0, 4);
    check("lz_all0_d0", 8'(seg), 8'h01);
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sseg_scan_ctrl
`default_nettype wire
